// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter that lets one of REQ_CNT requesters write a shared
// DATA_WIDTH-bit register per clock. The grant is purely combinational, so a
// requester sees req_rd in the same cycle it raises req_vld. The register
// loads on the edge that ends that cycle.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset; overrides everything else
//   en          arbitration enable; no grants while low
//   clr         synchronous clear of the shared register; blocks grants
//   req_vld     per-requester write request
//   req_data    packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rd      one-hot (or zero) write acceptance, same cycle as the request
//   dout        shared register contents
//   dout_upd    one-cycle pulse after dout was written or cleared
//   last_grant  index of the most recently accepted requester
module reg_write_arbiter #(
  parameter int REQ_CNT    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int PTR_W     = $clog2(REQ_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [REQ_CNT-1:0]            req_vld,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
  output logic [REQ_CNT-1:0]            req_rd,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_upd,
  output logic [PTR_W-1:0]              last_grant
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQ_CNT - 1);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [PTR_W-1:0]      last_q, last_d;
  logic                  upd_q, upd_d;

  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [PTR_W-1:0]      ptr_nxt;
  logic                  xfer;
  int                    scan_idx;

  // Scan ptr, ptr+1, ... modulo REQ_CNT and take the first valid requester.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    scan_idx   = 0;
    for (int k = 0; k < REQ_CNT; k++) begin
      scan_idx = (int'(ptr_q) + k) % REQ_CNT;
      if (!grant_vld && req_vld[scan_idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = PTR_W'(scan_idx);
        grant_data = req_data[scan_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset and clear both veto the grant in the cycle they are asserted, so a
  // requester caught by either stays pending and is re-arbitrated later.
  assign xfer    = grant_vld && en && !clr && !rst;
  assign ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

  always_comb begin
    req_rd = '0;
    if (xfer) begin
      req_rd[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    dout_d = dout_q;
    last_d = last_q;
    upd_d  = 1'b0;
    if (clr) begin
      dout_d = '0;
      upd_d  = 1'b1;
    end else if (xfer) begin
      dout_d = grant_data;
      last_d = grant_idx;
      ptr_d  = ptr_nxt;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      dout_q <= '0;
      last_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
      last_q <= last_d;
      upd_q  <= upd_d;
    end
  end

  assign dout       = dout_q;
  assign dout_upd   = upd_q;
  assign last_grant = last_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_rd;
  logic [7:0]  dout;
  logic        dout_upd;
  logic [1:0]  last_grant;

  int   nchecks = 0;
  int   nerr    = 0;
  int   m_ptr   = 0;
  logic [7:0] m_dout = 8'h00;
  logic [1:0] m_last = 2'd0;
  exp_t sb[$];

  reg_write_arbiter #(.REQ_CNT(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .req_vld(req_vld), .req_data(req_data),
    .req_rd(req_rd), .dout(dout), .dout_upd(dout_upd), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: computes the expected grant for the current inputs and
  // pushes the expected register write (if any) onto the scoreboard.
  task automatic model_step(output logic [3:0] exp_rd);
    int   g;
    exp_t e;
    exp_rd = '0;
    if (rst) begin
      m_ptr = 0; m_dout = '0; m_last = '0;
      sb.delete();
    end else if (clr) begin
      m_dout = '0;
      e.d = 8'h00; e.idx = m_last;
      sb.push_back(e);
    end else if (en) begin
      g = pick(req_vld, m_ptr);
      if (g >= 0) begin
        exp_rd[g] = 1'b1;
        m_dout = req_data[g*8 +: 8];
        m_last = 2'(g);
        m_ptr  = (g + 1) % 4;
        e.d = m_dout; e.idx = m_last;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    logic [3:0] er;
    rst = 1'b1; en = 1'b0; clr = 1'b0; req_vld = '0;
    @(negedge clk); model_step(er);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] er;
    rst = 1'b1; en = 1'b1; clr = 1'b1; req_vld = 4'hF; req_data = 32'h11223344;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL reset_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout !== 8'h00 || dout_upd !== 1'b0 || last_grant !== 2'd0) begin
        nerr++; $display("FAIL reset_state c=%0d: dout=%h upd=%b last=%0d expected 00/0/0", c, dout, dout_upd, last_grant);
      end
    end
    rst = 1'b0; clr = 1'b0; req_vld = '0;
  endtask

  task automatic test_single();
    logic [3:0] er;
    exp_t e;
    logic [3:0] vt [2] = '{4'b0001, 4'b0000};
    for (int c = 0; c < 2; c++) begin
      en = 1'b1; clr = 1'b0; req_vld = vt[c]; req_data = $urandom(); req_data[7:0] = 8'hA5;
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL single_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL single_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL single_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      en = 1'b1; clr = 1'b0; req_vld = 4'hF; req_data = $urandom();
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er || req_rd !== seq[c]) begin nerr++; $display("FAIL rr_rd c=%0d: req_rd=%b expected %b", c, req_rd, seq[c]); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL rr_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL rr_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] er;
    exp_t e;
    logic [3:0] vt [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0000};
    for (int c = 0; c < 4; c++) begin
      en = 1'b1; clr = 1'b0; req_vld = vt[c]; req_data = $urandom();
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL wrap_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL wrap_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL wrap_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
  endtask

  task automatic test_clear();
    logic [3:0] er;
    exp_t e;
    logic [3:0] vt [4] = '{4'b0010, 4'b0010, 4'b1010, 4'b0000};
    logic       ct [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      en = 1'b1; clr = ct[c]; req_vld = vt[c]; req_data = $urandom(); req_data[15:8] = 8'h3C;
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL clear_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL clear_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL clear_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
    clr = 1'b0;
  endtask

  task automatic test_enable();
    logic [3:0] er;
    exp_t e;
    logic [3:0] vt [5] = '{4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic       et [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 5; c++) begin
      en = et[c]; clr = 1'b0; req_vld = vt[c]; req_data = $urandom();
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL enable_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL enable_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL enable_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
  endtask

  task automatic test_same_data();
    logic [3:0] er;
    exp_t e;
    logic [3:0] vt [2] = '{4'b1000, 4'b0000};
    for (int c = 0; c < 2; c++) begin
      en = 1'b1; clr = 1'b0; req_vld = vt[c]; req_data = $urandom(); req_data[31:24] = m_dout;
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL same_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL same_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL same_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
  endtask

  task automatic test_rst_mid();
    logic [3:0] er;
    exp_t e;
    logic [3:0] vt [5] = '{4'b0010, 4'b0100, 4'b0100, 4'b1111, 4'b0000};
    logic       rt [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      rst = rt[c]; en = 1'b1; clr = rt[c]; req_vld = vt[c]; req_data = $urandom();
      @(negedge clk); model_step(er);
      nchecks++;
      if (req_rd !== er) begin nerr++; $display("FAIL rstmid_rd c=%0d: req_rd=%b expected %b", c, req_rd, er); end
      @(posedge clk); #1;
      nchecks++;
      if (dout_upd !== (sb.size() != 0)) begin nerr++; $display("FAIL rstmid_upd c=%0d: dout_upd=%b expected %b", c, dout_upd, sb.size() != 0); end
      if (sb.size() != 0) e = sb.pop_front(); else begin e.d = m_dout; e.idx = m_last; end
      nchecks++;
      if (dout !== e.d || last_grant !== e.idx) begin nerr++; $display("FAIL rstmid_dout c=%0d: dout=%h last=%0d expected %h/%0d", c, dout, last_grant, e.d, e.idx); end
    end
    rst = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; req_vld = '0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_clear();
    test_enable();
    test_same_data();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
